operand_dispatch: RTL and testbench
===================================

OPERAND_DISPATCH -- requirements
Module: operand_dispatch

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 Parameter NUM_BITS, default 32: operand width in bits.
REQ-003 Parameter NUM_CH, default 8: number of destination channels, legal range 2..32.
REQ-004 Parameter SEL_W, default 3: select width; the block SHALL require 2**SEL_W >= NUM_CH.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  operand pair offered.
REQ-008 in_ready  out  1  block accepts the offered pair this cycle.
REQ-009 in_sel  in  SEL_W  destination channel index.
REQ-010 in_op1, in_op2  in  NUM_BITS each  operand pair.
REQ-011 ch_valid  out  NUM_CH  per-channel buffer holds a pair.
REQ-012 ch_ready  in  NUM_CH  per-channel consumer takes the pair.
REQ-013 ch_op1, ch_op2  out  NUM_CH*NUM_BITS each  flattened per-channel operands; channel i occupies bits [i*NUM_BITS +: NUM_BITS].
REQ-014 occupancy  out  SEL_W+1  count of channels with ch_valid high.

Function
REQ-015 Each channel SHALL have a one-entry buffer: full flag, op1 register and op2 register.
REQ-016 The accept condition is: in_valid and in_ready both high, with in_sel < NUM_CH.
REQ-017 in_ready SHALL equal (in_sel >= NUM_CH) OR !full[in_sel] OR ch_ready[in_sel], combinationally.
REQ-018 On accept, buffer[in_sel] SHALL capture in_op1/in_op2 and set full at the next edge: latency of exactly 1 cycle from input to ch_valid.
REQ-019 ch_valid[i] SHALL equal full[i].
REQ-020 ch_op1/ch_op2 of channel i SHALL present the buffer contents when full[i]; otherwise they SHALL be all zeros.
REQ-021 Drain: when full[i] and ch_ready[i] are both high, full[i] SHALL clear at the next edge unless the same cycle also accepts into channel i.
REQ-022 When accept and drain hit the same channel in the same cycle, the channel SHALL stay full and hold the new pair, with no bubble.
REQ-023 While ch_valid[i] is high and ch_ready[i] is low, channel i data SHALL be held stable.
REQ-024 Accepts and drains on different channels in the same cycle SHALL be independent.
REQ-025 occupancy SHALL be registered and equal to the popcount of full after every edge, range 0..NUM_CH.
REQ-026 A request with in_sel >= NUM_CH SHALL be consumed (in_ready high) and discarded, with no buffer change.
REQ-027 ch_ready[i] while full[i] is low SHALL have no effect.

Reset
REQ-028 While rst is high at an edge: all full flags, all buffer data, occupancy and bad_sel_err SHALL clear to 0.
REQ-029 Pairs held or offered in a reset cycle SHALL be dropped; in_ready SHALL still follow REQ-017 combinationally.
REQ-030 After rst deasserts, the first accept SHALL be possible in the same cycle.

Configuration
REQ-031 Macro OPERAND_DISPATCH_BAD_SEL_EN, when defined, SHALL add output bad_sel_err  out  1, a sticky flag.
REQ-032 bad_sel_err SHALL set at the edge following any cycle with in_valid high and in_sel >= NUM_CH, and SHALL clear only on rst.
REQ-033 Without OPERAND_DISPATCH_BAD_SEL_EN, the port SHALL be absent and out-of-range requests SHALL be discarded silently per REQ-026.

Verification
REQ-034 Reset, then offer in_sel=2, op1=0x3F800000, op2=0x40000000 -> the next cycle shows ch_valid=0x04, channel 2 carries those values, all other channels read 0, occupancy=1.
REQ-035 Channel 5 full with ch_ready[5]=0, offer in_sel=5 -> in_ready=0 and data is held; raise ch_ready[5] in the same cycle as a new offer -> accepted, and the next cycle channel 5 holds the new pair with ch_valid[5] still 1.
REQ-036 Fill channels 0..7 on 8 consecutive cycles with ch_ready=0 -> occupancy steps 1..8; set ch_ready=0xFF for one cycle -> occupancy=0 and ch_valid=0.
REQ-037 NUM_CH=6, SEL_W=3, offer in_sel=7 -> in_ready=1 and no channel changes; bad_sel_err=1 the next cycle with OPERAND_DISPATCH_BAD_SEL_EN, port absent without it.
REQ-038 With channels 1 and 3 full, assert rst for one cycle while in_valid=1 and in_sel=4 -> ch_valid=0 and occupancy=0 after the edge, and channel 4 stays empty.

Source files
------------

// File: rtl/operand_dispatch.sv
// Routes an operand pair to one of NUM_CH one-entry channel buffers with valid/ready flow control.
// Optional sticky out-of-range select flag: define OPERAND_DISPATCH_BAD_SEL_EN.
module operand_dispatch #(
  parameter int NUM_BITS = 32,
  parameter int NUM_CH   = 8,
  parameter int SEL_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SEL_W-1:0]           in_sel,
  input  logic [NUM_BITS-1:0]        in_op1,
  input  logic [NUM_BITS-1:0]        in_op2,
  output logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_ready,
  output logic [NUM_CH*NUM_BITS-1:0] ch_op1,
  output logic [NUM_CH*NUM_BITS-1:0] ch_op2,
  output logic [SEL_W:0]             occupancy
`ifdef OPERAND_DISPATCH_BAD_SEL_EN
  ,output logic                      bad_sel_err
`endif
);

  localparam int NPAD = 1 << SEL_W;

  if (NPAD < NUM_CH || NUM_CH < 2 || NUM_CH > 32) begin : g_bad_cfg
    $error("operand_dispatch: illegal NUM_CH/SEL_W combination");
  end

  function automatic logic [SEL_W:0] f_popcount(input logic [NUM_CH-1:0] v);
    logic [SEL_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) c = c + {{SEL_W{1'b0}}, v[i]};
    return c;
  endfunction

  logic [NUM_CH-1:0]   r_full_p1;
  logic [NUM_BITS-1:0] r_op1_p1 [NUM_CH];
  logic [NUM_BITS-1:0] r_op2_p1 [NUM_CH];
  logic [SEL_W:0]      r_occ_p1;

  logic [NPAD-1:0]     w_full_pad;
  logic [NPAD-1:0]     w_rdy_pad;
  logic                w_sel_oob;
  logic                w_acc;
  logic [NUM_CH-1:0]   w_acc_vec;
  logic [NUM_CH-1:0]   w_full_nxt;

  // Padding to the full select range lets out-of-range selects index safely.
  assign w_full_pad = NPAD'(r_full_p1);
  assign w_rdy_pad  = NPAD'(ch_ready);
  assign w_sel_oob  = ({1'b0, in_sel} >= (SEL_W+1)'(NUM_CH));
  assign in_ready   = w_sel_oob | ~w_full_pad[in_sel] | w_rdy_pad[in_sel];
  assign w_acc      = in_valid & in_ready & ~w_sel_oob;

  always_comb begin
    w_acc_vec  = '0;
    w_full_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_acc_vec[i]  = w_acc && (in_sel == SEL_W'(i));
      w_full_nxt[i] = w_acc_vec[i] | (r_full_p1[i] & ~ch_ready[i]);
    end
  end

  // Stage p1: channel buffers and registered occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full_p1 <= '0;
      r_occ_p1  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_op1_p1[i] <= '0;
        r_op2_p1[i] <= '0;
      end
    end else begin
      r_full_p1 <= w_full_nxt;
      r_occ_p1  <= f_popcount(w_full_nxt);
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_acc_vec[i]) begin
          r_op1_p1[i] <= in_op1;
          r_op2_p1[i] <= in_op2;
        end
      end
    end
  end

  assign ch_valid  = r_full_p1;
  assign occupancy = r_occ_p1;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
    assign ch_op1[g*NUM_BITS +: NUM_BITS] = r_full_p1[g] ? r_op1_p1[g] : '0;
    assign ch_op2[g*NUM_BITS +: NUM_BITS] = r_full_p1[g] ? r_op2_p1[g] : '0;
  end

`ifdef OPERAND_DISPATCH_BAD_SEL_EN
  logic r_bad_sel_p1;

  always_ff @(posedge clk) begin
    if (rst)                         r_bad_sel_p1 <= 1'b0;
    else if (in_valid && w_sel_oob)  r_bad_sel_p1 <= 1'b1;
  end

  assign bad_sel_err = r_bad_sel_p1;
`endif

endmodule

// File: tb/tb_operand_dispatch.sv
// Scoreboard bench for operand_dispatch: 8-channel main instance plus a 6-channel instance for out-of-range selects.
module tb_operand_dispatch;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main instance (defaults)
  logic         rst, in_valid, in_ready;
  logic [2:0]   in_sel;
  logic [31:0]  in_op1, in_op2;
  logic [7:0]   ch_valid, ch_ready;
  logic [255:0] ch_op1, ch_op2;
  logic [3:0]   occupancy;
`ifdef OPERAND_DISPATCH_BAD_SEL_EN
  logic         bad_sel_err;
`endif

  operand_dispatch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_op1(in_op1), .in_op2(in_op2), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_op1(ch_op1), .ch_op2(ch_op2), .occupancy(occupancy)
`ifdef OPERAND_DISPATCH_BAD_SEL_EN
    , .bad_sel_err(bad_sel_err)
`endif
  );

  // Six-channel instance
  logic         b_rst, b_in_valid, b_in_ready;
  logic [2:0]   b_in_sel;
  logic [31:0]  b_in_op1, b_in_op2;
  logic [5:0]   b_ch_valid, b_ch_ready;
  logic [191:0] b_ch_op1, b_ch_op2;
  logic [3:0]   b_occupancy;
`ifdef OPERAND_DISPATCH_BAD_SEL_EN
  logic         b_bad_sel_err;
`endif

  operand_dispatch #(.NUM_BITS(32), .NUM_CH(6), .SEL_W(3)) dut6 (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel),
    .in_op1(b_in_op1), .in_op2(b_in_op2), .ch_valid(b_ch_valid), .ch_ready(b_ch_ready),
    .ch_op1(b_ch_op1), .ch_op2(b_ch_op2), .occupancy(b_occupancy)
`ifdef OPERAND_DISPATCH_BAD_SEL_EN
    , .bad_sel_err(b_bad_sel_err)
`endif
  );

  // Reference model of the main instance
  logic [7:0]  m_full;
  logic [31:0] m_op1 [8];
  logic [31:0] m_op2 [8];

  typedef struct { int ch; logic [31:0] op1; logic [31:0] op2; } exp_t;
  exp_t sbq [$];

  // One clock cycle on the main instance: drive, check in_ready, clock, check outputs.
  task automatic cycle(input logic r, input logic v, input logic [2:0] sel,
                       input logic [31:0] o1, input logic [31:0] o2, input logic [7:0] rdy);
    logic       exp_rdy, acc;
    logic [7:0] nf;
    exp_t       e;
    int         cnt;
    rst = r; in_valid = v; in_sel = sel; in_op1 = o1; in_op2 = o2; ch_ready = rdy;
    #1;
    exp_rdy = !m_full[sel] || rdy[sel];
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_errors++;
      $display("FAIL in_ready sel=%0d got %b exp %b", sel, in_ready, exp_rdy);
    end
    acc = v && exp_rdy && !r;
    if (r) begin
      m_full = '0;
      for (int i = 0; i < 8; i++) begin m_op1[i] = '0; m_op2[i] = '0; end
    end else begin
      for (int i = 0; i < 8; i++) nf[i] = (acc && sel == 3'(i)) || (m_full[i] && !rdy[i]);
      m_full = nf;
      if (acc) begin
        m_op1[sel] = o1; m_op2[sel] = o2;
        e.ch = int'(sel); e.op1 = o1; e.op2 = o2;
        sbq.push_back(e);
      end
    end
    @(posedge clk); #1;
    cnt = $countones(m_full);
    n_checks++;
    if (ch_valid !== m_full) begin
      n_errors++;
      $display("FAIL ch_valid got %h exp %h", ch_valid, m_full);
    end
    n_checks++;
    if (occupancy !== 4'(cnt)) begin
      n_errors++;
      $display("FAIL occupancy got %0d exp %0d", occupancy, cnt);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_checks++;
      if (ch_op1[e.ch*32 +: 32] !== e.op1 || ch_op2[e.ch*32 +: 32] !== e.op2) begin
        n_errors++;
        $display("FAIL accept_data ch=%0d got %h/%h exp %h/%h", e.ch,
                 ch_op1[e.ch*32 +: 32], ch_op2[e.ch*32 +: 32], e.op1, e.op2);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (ch_op1[i*32 +: 32] !== (m_full[i] ? m_op1[i] : 32'h0) ||
          ch_op2[i*32 +: 32] !== (m_full[i] ? m_op2[i] : 32'h0)) begin
        n_errors++;
        $display("FAIL ch_data ch=%0d got %h/%h exp %h/%h", i, ch_op1[i*32 +: 32],
                 ch_op2[i*32 +: 32], m_full[i] ? m_op1[i] : 32'h0, m_full[i] ? m_op2[i] : 32'h0);
      end
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 8'h00);
    cycle(1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 8'h00);
  endtask

  task automatic test_single();
    cycle(1'b0, 1'b1, 3'd2, 32'h3F80_0000, 32'h4000_0000, 8'h00);
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 8'h00);
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 8'h04);
  endtask

  task automatic test_backpressure();
    cycle(1'b0, 1'b1, 3'd5, 32'hAAAA_0001, 32'hBBBB_0001, 8'h00);
    cycle(1'b0, 1'b1, 3'd5, 32'hAAAA_0002, 32'hBBBB_0002, 8'h00);
    cycle(1'b0, 1'b1, 3'd5, 32'hAAAA_0003, 32'hBBBB_0003, 8'h20);
    cycle(1'b0, 1'b0, 3'd5, 32'h0, 32'h0, 8'hDF);
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 8'h20);
  endtask

  task automatic test_fill();
    cycle(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 8'h00);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, 3'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), 8'h00);
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 8'hFF);
  endtask

  task automatic test_reset_drop();
    cycle(1'b0, 1'b1, 3'd1, 32'h1111_1111, 32'h2222_2222, 8'h00);
    cycle(1'b0, 1'b1, 3'd3, 32'h3333_3333, 32'h4444_4444, 8'h00);
    cycle(1'b1, 1'b1, 3'd4, 32'h5555_5555, 32'h6666_6666, 8'h00);
    cycle(1'b0, 1'b1, 3'd6, 32'h7777_7777, 32'h8888_8888, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++)
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            $urandom, $urandom, 8'($urandom));
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 8'hFF);
  endtask

  task automatic test_bad_sel();
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_sel = 3'd0; b_in_op1 = '0; b_in_op2 = '0; b_ch_ready = '0;
    @(posedge clk); #1;
    b_rst = 1'b0; b_in_valid = 1'b1; b_in_sel = 3'd7;
    b_in_op1 = 32'hCAFE_0007; b_in_op2 = 32'hF00D_0007;
    #1;
    n_checks++;
    if (b_in_ready !== 1'b1) begin
      n_errors++; $display("FAIL oob_ready got %b exp 1", b_in_ready);
    end
`ifdef OPERAND_DISPATCH_BAD_SEL_EN
    n_checks++;
    if (b_bad_sel_err !== 1'b0) begin
      n_errors++; $display("FAIL bad_sel_pre got %b exp 0", b_bad_sel_err);
    end
`endif
    @(posedge clk); #1;
    b_in_sel = 3'd6;
    #1;
    n_checks++;
    if (b_ch_valid !== 6'h00 || b_occupancy !== 4'd0 || b_ch_op1 !== '0 || b_ch_op2 !== '0) begin
      n_errors++; $display("FAIL oob_discard got vld=%h occ=%0d exp 0/0", b_ch_valid, b_occupancy);
    end
    n_checks++;
    if (b_in_ready !== 1'b1) begin
      n_errors++; $display("FAIL oob6_ready got %b exp 1", b_in_ready);
    end
`ifdef OPERAND_DISPATCH_BAD_SEL_EN
    n_checks++;
    if (b_bad_sel_err !== 1'b1) begin
      n_errors++; $display("FAIL bad_sel_set got %b exp 1", b_bad_sel_err);
    end
`endif
    @(posedge clk); #1;
    b_in_sel = 3'd5; b_in_op1 = 32'h0000_0555; b_in_op2 = 32'h0000_0AAA;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    n_checks++;
    if (b_ch_valid !== 6'h20 || b_occupancy !== 4'd1 ||
        b_ch_op1[5*32 +: 32] !== 32'h0000_0555 || b_ch_op2[5*32 +: 32] !== 32'h0000_0AAA) begin
      n_errors++; $display("FAIL ch5_of6 got vld=%h occ=%0d op1=%h exp 20/1/00000555",
                           b_ch_valid, b_occupancy, b_ch_op1[5*32 +: 32]);
    end
`ifdef OPERAND_DISPATCH_BAD_SEL_EN
    n_checks++;
    if (b_bad_sel_err !== 1'b1) begin
      n_errors++; $display("FAIL bad_sel_sticky got %b exp 1", b_bad_sel_err);
    end
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    n_checks++;
    if (b_bad_sel_err !== 1'b0 || b_ch_valid !== 6'h00) begin
      n_errors++; $display("FAIL bad_sel_clear got %b/%h exp 0/00", b_bad_sel_err, b_ch_valid);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_op1 = '0; in_op2 = '0; ch_ready = '0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_sel = '0; b_in_op1 = '0; b_in_op2 = '0; b_ch_ready = '0;
    m_full = '0;
    for (int i = 0; i < 8; i++) begin m_op1[i] = '0; m_op2[i] = '0; end
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_reset_drop();
    test_back_to_back();
    test_bad_sel();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
